// File: rtl/data_memory32_core.sv
// Word-organised data memory behind the KLP32 load/store unit.
// Flop-based array so the asynchronous reset can clear every word; reads are combinational.
module data_memory32_core #(
  parameter int N     = 32,
  parameter int DEPTH = 1024,
  parameter int AW    = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         write_enable,
  input  logic [N-1:0] addr,
  input  logic [N-1:0] write_data,
  output logic [N-1:0] read_data
);

  logic [N-1:0]  mem_q [DEPTH];
  logic [N-1:0]  mem_d [DEPTH];
  logic          in_range;
  logic          wr_hit;
  logic [AW-1:0] idx;

  // Any set bit above the index field means out of range: no aliasing onto low words.
  assign in_range = (addr[N-1:AW] == '0);
  assign idx      = addr[AW-1:0];

  // An X on write_enable fails the equality test, so it behaves as no write.
  assign wr_hit = (write_enable == 1'b1) && in_range;

  always_comb begin
    mem_d = mem_q;
    if (wr_hit) begin
      mem_d[idx] = write_data;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q <= '{default: '0};
    end else begin
      mem_q <= mem_d;
    end
  end

  assign read_data = in_range ? mem_q[idx] : '0;

endmodule

// File: tb/tb_data_memory32_core.sv
// Bench for data_memory32_core: directed scenarios then random traffic
// compared against a plain array model of the memory.
module tb_data_memory32_core;

  localparam int DEPTH = 1024;

  logic        clk;
  logic        rst_n;
  logic        write_enable;
  logic [31:0] addr;
  logic [31:0] write_data;
  logic [31:0] read_data;

  int checks = 0;
  int errors = 0;

  logic [31:0] ref_mem [DEPTH];

  data_memory32_core dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .write_enable (write_enable),
    .addr         (addr),
    .write_data   (write_data),
    .read_data    (read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] model_read(input logic [31:0] a);
    if (a < DEPTH) return ref_mem[a];
    return 32'h0;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = 32'h0;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Drive one cycle: check old contents before the edge, new contents after it.
  task automatic cycle(input logic we, input logic [31:0] a, input logic [31:0] d, input string tag);
    @(negedge clk);
    write_enable = we;
    addr         = a;
    write_data   = d;
    #1 check({tag, "_pre"}, read_data, model_read(a));
    @(posedge clk);
    if (we && a < DEPTH) ref_mem[a] = d;
    #1 check({tag, "_post"}, read_data, model_read(a));
  endtask

  task automatic read_at(input logic [31:0] a, input string tag);
    addr = a;
    #1 check(tag, read_data, model_read(a));
  endtask

  initial begin
    logic [31:0] a;
    logic [31:0] d;
    logic        we;

    rst_n        = 1'b0;
    write_enable = 1'b0;
    addr         = 32'd1;
    write_data   = 32'h0;
    model_clear();
    #12;
    check("reset_read", read_data, 32'h0);
    rst_n = 1'b1;

    cycle(1'b1, 32'd1, 32'hDEADBEEF, "wr1");
    write_enable = 1'b0;
    read_at(32'd1, "rd1");
    check("rd1_const", read_data, 32'hDEADBEEF);

    cycle(1'b1, 32'd2, 32'h12345678, "wr2");
    write_enable = 1'b0;
    read_at(32'd2, "rd2");
    read_at(32'd1, "rd1_isolation");
    read_at(32'd3, "unwritten");
    check("unwritten_const", read_data, 32'h0);

    // Combinational read: change inputs mid-cycle, no edge in between.
    @(posedge clk);
    #1;
    write_enable = 1'b1;
    addr         = 32'd4;
    write_data   = 32'h91827364;
    #5;
    write_enable = 1'b0;
    addr         = 32'd1;
    #1 check("comb_read", read_data, 32'hDEADBEEF);
    addr = 32'd4;
    #1 check("no_edge_no_write", read_data, 32'h0);

    // Async reset between edges.
    @(negedge clk);
    addr = 32'd1;
    #1 check("pre_async", read_data, 32'hDEADBEEF);
    #1 rst_n = 1'b0;
    #1 check("async_clear", read_data, 32'h0);
    #1 rst_n = 1'b1;
    model_clear();
    #1 check("after_release", read_data, 32'h0);

    // Range handling.
    cycle(1'b1, 32'd0, 32'h11110000, "wr0");
    cycle(1'b1, 32'd1024, 32'hCAFEF00D, "wr1024");
    write_enable = 1'b0;
    read_at(32'd1024, "rd1024");
    read_at(32'd0, "rd0_unchanged");
    check("rd0_const", read_data, 32'h11110000);
    cycle(1'b1, 32'h0000_0401, 32'h55AA55AA, "wr1025");
    cycle(1'b1, 32'h8000_0002, 32'h77777777, "wr_hibit");
    write_enable = 1'b0;
    read_at(32'd1, "no_alias_1");
    read_at(32'd2, "no_alias_2");

    // Read-during-write: old value before the edge, new after.
    @(negedge clk);
    write_enable = 1'b1;
    addr         = 32'd5;
    write_data   = 32'hA5A5A5A5;
    #1 check("rdw_before", read_data, 32'h0);
    @(posedge clk);
    ref_mem[5] = 32'hA5A5A5A5;
    #1 check("rdw_after", read_data, 32'hA5A5A5A5);

    cycle(1'b0, 32'd6, 32'hFFFFFFFF, "we0");
    cycle(1'b1, 32'd6, 32'hFFFFFFFF, "wr6_ones");

    // Random traffic, mostly into a small window so reads hit written words.
    for (int i = 0; i < 300; i++) begin
      we = ($urandom_range(0, 2) != 0);
      case ($urandom_range(0, 9))
        0:       a = $urandom_range(DEPTH, 2 * DEPTH - 1);
        1:       a = $urandom | 32'h0000_0400;
        2:       a = $urandom_range(0, DEPTH - 1);
        default: a = $urandom_range(0, 15);
      endcase
      d = $urandom;
      cycle(we, a, d, "rand");
    end
    write_enable = 1'b0;
    for (int k = 0; k < 16; k++) read_at(k, "sweep");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
